// File: rtl/i2c_passthru_bus_recover_if.sv
// Bus-side signal bundle for the I2C bus-clear sequencer: reference tick,
// request strobe, sampled bus levels in; open-drain enables and status out.
interface i2c_passthru_bus_recover_if;
  logic i_f_ref;
  logic i_start;
  logic i_sda;
  logic i_scl;
  logic o_scl_oe;
  logic o_sda_oe;
  logic o_busy;
  logic o_done;
  logic o_fail;

  // The recovery block itself.
  modport slave (
    input  i_f_ref, i_start, i_sda, i_scl,
    output o_scl_oe, o_sda_oe, o_busy, o_done, o_fail
  );

  // Whoever requests recovery and supplies the bus levels.
  modport master (
    output i_f_ref, i_start, i_sda, i_scl,
    input  o_scl_oe, o_sda_oe, o_busy, o_done, o_fail
  );
endinterface

// File: rtl/i2c_passthru_bus_recover.sv
// I2C bus-clear sequencer. Releases SDA, clocks SCL until the target lets go
// of SDA (or the pulse budget runs out), then issues a STOP. Phase timing is
// counted in i_f_ref ticks; external SCL stretching is tolerated up to a limit.
module i2c_passthru_bus_recover #(
  parameter int F_REF_T_LOW       = 38,
  parameter int WIDTH_F_REF_T_LOW = 6,
  parameter int RECOVER_PULSES    = 9,
  parameter int STRETCH_MAX       = 255,
  parameter int WIDTH_STRETCH     = 8
) (
  input logic                         i_clk,
  input logic                         i_rst,
  i2c_passthru_bus_recover_if.slave   bus
);

  localparam logic [WIDTH_F_REF_T_LOW-1:0] T_LOW_LOAD    = WIDTH_F_REF_T_LOW'(F_REF_T_LOW);
  localparam logic [WIDTH_STRETCH-1:0]     STRETCH_LIMIT = WIDTH_STRETCH'(STRETCH_MAX);
  localparam logic [3:0]                   PULSE_LIMIT   = 4'(RECOVER_PULSES);

  // Four bits so that unused encodings exist and fall back to idle.
  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_SCL_LOW     = 4'd1,
    ST_SCL_HIGH    = 4'd2,
    ST_STOP_SETUP  = 4'd3,
    ST_STOP_SCL_HI = 4'd4,
    ST_STOP_SDA_HI = 4'd5,
    ST_DONE        = 4'd6,
    ST_FAIL        = 4'd7
  } state_t;

  state_t                       state_reg;
  state_t                       state_next;
  logic [WIDTH_F_REF_T_LOW-1:0] timer_reg;
  logic [WIDTH_STRETCH-1:0]     stretch_reg;
  logic [3:0]                   pulse_reg;
  logic                         f_ref_prev_reg;

  logic       f_ref_tick;
  logic       timer_zero;
  logic       stretch_full;
  logic       stretch_phase;
  logic       stretched;
  logic       state_change;
  logic       pulse_step;
  logic [3:0] pulse_inc;

  assign f_ref_tick    = bus.i_f_ref & ~f_ref_prev_reg;
  assign timer_zero    = (timer_reg == '0);
  assign stretch_full  = (stretch_reg == STRETCH_LIMIT);
  // Phases where SCL is released and another agent may hold it low.
  assign stretch_phase = (state_reg == ST_SCL_HIGH) || (state_reg == ST_STOP_SCL_HI);
  assign stretched     = stretch_phase && !bus.i_scl;
  assign state_change  = (state_next != state_reg);
  assign pulse_inc     = pulse_reg + 4'd1;
  // A recovery pulse completes when its high phase times out with SCL really high.
  assign pulse_step    = (state_reg == ST_SCL_HIGH) && bus.i_scl && timer_zero;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode; the SDA check is ahead of the pulse budget check.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.i_start) begin
          if (!bus.i_scl) begin
            state_next = ST_FAIL;
          end else if (bus.i_sda) begin
            state_next = ST_STOP_SETUP;
          end else begin
            state_next = ST_SCL_LOW;
          end
        end
      end
      ST_SCL_LOW: begin
        if (timer_zero) state_next = ST_SCL_HIGH;
      end
      ST_SCL_HIGH: begin
        if (!bus.i_scl) begin
          if (stretch_full) state_next = ST_FAIL;
        end else if (timer_zero) begin
          if (bus.i_sda) begin
            state_next = ST_STOP_SETUP;
          end else if (pulse_inc == PULSE_LIMIT) begin
            state_next = ST_FAIL;
          end else begin
            state_next = ST_SCL_LOW;
          end
        end
      end
      ST_STOP_SETUP: begin
        if (timer_zero) state_next = ST_STOP_SCL_HI;
      end
      ST_STOP_SCL_HI: begin
        if (!bus.i_scl) begin
          if (stretch_full) state_next = ST_FAIL;
        end else if (timer_zero) begin
          state_next = ST_STOP_SDA_HI;
        end
      end
      ST_STOP_SDA_HI: begin
        if (timer_zero) begin
          state_next = (bus.i_sda && bus.i_scl) ? ST_DONE : ST_FAIL;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      ST_FAIL: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Phase timer, stretch counter, pulse counter and tick edge history.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      timer_reg      <= '0;
      stretch_reg    <= '0;
      pulse_reg      <= '0;
      f_ref_prev_reg <= 1'b0;
    end else begin
      f_ref_prev_reg <= bus.i_f_ref;
      if (state_change) begin
        timer_reg   <= T_LOW_LOAD;
        stretch_reg <= '0;
      end else if (stretched) begin
        // Held low externally: the high phase restarts once SCL is released.
        timer_reg <= T_LOW_LOAD;
        if (f_ref_tick && !stretch_full) begin
          stretch_reg <= stretch_reg + WIDTH_STRETCH'(1);
        end
      end else if (f_ref_tick && !timer_zero) begin
        timer_reg <= timer_reg - WIDTH_F_REF_T_LOW'(1);
      end
      if (state_reg == ST_IDLE) begin
        pulse_reg <= '0;
      end else if (pulse_step) begin
        pulse_reg <= pulse_inc;
      end
    end
  end

  // Output decode from the state register only.
  always_comb begin
    bus.o_scl_oe = 1'b0;
    bus.o_sda_oe = 1'b0;
    bus.o_busy   = (state_reg != ST_IDLE);
    bus.o_done   = 1'b0;
    bus.o_fail   = 1'b0;
    case (state_reg)
      ST_SCL_LOW:     bus.o_scl_oe = 1'b1;
      ST_STOP_SETUP: begin
        bus.o_scl_oe = 1'b1;
        bus.o_sda_oe = 1'b1;
      end
      ST_STOP_SCL_HI: bus.o_sda_oe = 1'b1;
      ST_DONE:        bus.o_done   = 1'b1;
      ST_FAIL:        bus.o_fail   = 1'b1;
      default: begin
        bus.o_scl_oe = 1'b0;
        bus.o_sda_oe = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_passthru_bus_recover.sv
// Directed bench for the bus-clear sequencer: open-drain bus with a simple
// target that holds SDA low for a set number of SCL high phases and can
// stretch one high phase.
module tb_i2c_passthru_bus_recover;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  i2c_passthru_bus_recover_if bus ();

  i2c_passthru_bus_recover #(
    .F_REF_T_LOW      (4),
    .WIDTH_F_REF_T_LOW(3),
    .RECOVER_PULSES   (9),
    .STRETCH_MAX      (8),
    .WIDTH_STRETCH    (8)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Target behaviour knobs, written only by the stimulus block.
  logic tgt_sda_en   = 1'b0;
  int   rel_after    = 0;
  logic scl_force    = 1'b0;
  int   str_pulse    = 0;
  int   str_len      = 0;
  int   base_high    = 0;

  // Monitor state, written only by the monitor.
  int   n_pulse      = 0;
  int   n_high       = 0;
  int   n_stop       = 0;
  int   n_any_oe     = 0;
  int   stretch_rem  = 0;
  logic prev_scl_oe  = 1'b0;
  logic prev_sda_oe  = 1'b0;
  logic prev_f_ref   = 1'b0;

  logic tgt_sda_low;
  logic tgt_scl_low;
  assign tgt_sda_low = tgt_sda_en && ((n_high - base_high) < rel_after);
  assign tgt_scl_low = scl_force || (stretch_rem != 0);
  assign bus.i_sda   = ~bus.o_sda_oe & ~tgt_sda_low;
  assign bus.i_scl   = ~bus.o_scl_oe & ~tgt_scl_low;

  // Reference tick: high for one clk out of every four.
  initial begin
    bus.i_f_ref = 1'b0;
    for (int c = 0; c < 60000; c++) begin
      @(posedge clk);
      #1;
      bus.i_f_ref = ((c % 4) == 0);
    end
  end

  // Bus monitor and target stretch model, sampled on the falling edge.
  always @(negedge clk) begin
    prev_scl_oe <= bus.o_scl_oe;
    prev_sda_oe <= bus.o_sda_oe;
    prev_f_ref  <= bus.i_f_ref;
    if (bus.o_scl_oe === 1'b1 && prev_scl_oe === 1'b0 && bus.o_sda_oe === 1'b0)
      n_pulse <= n_pulse + 1;
    if (bus.o_scl_oe === 1'b0 && prev_scl_oe === 1'b1 && bus.o_sda_oe === 1'b0) begin
      n_high <= n_high + 1;
      if (n_high + 1 - base_high == str_pulse) stretch_rem <= str_len;
    end else if (bus.i_f_ref && !prev_f_ref && stretch_rem != 0) begin
      stretch_rem <= stretch_rem - 1;
    end
    if (prev_sda_oe === 1'b1 && bus.o_sda_oe === 1'b0 && bus.i_sda === 1'b1 && bus.i_scl === 1'b1)
      n_stop <= n_stop + 1;
    if (bus.o_scl_oe === 1'b1 || bus.o_sda_oe === 1'b1)
      n_any_oe <= n_any_oe + 1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick_clk(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle request; returns #1 after the edge that sampled it.
  task automatic pulse_start();
    bus.i_start = 1'b1;
    tick_clk(1);
    bus.i_start = 1'b0;
  endtask

  // Wait (bounded) for o_done or o_fail and check the pulse/busy framing.
  task automatic wait_end(input string tag, input int want_done);
    int seen;
    seen = 0;
    for (int k = 0; k < 3000; k++) begin
      tick_clk(1);
      if (bus.o_done === 1'b1 || bus.o_fail === 1'b1) begin
        seen = 1;
        break;
      end
    end
    check({tag, "_ended"}, seen, 1);
    $display("%s: done=%0d fail=%0d busy=%0d pulses=%0d stops=%0d", tag,
             bus.o_done, bus.o_fail, bus.o_busy, n_pulse, n_stop);
    check({tag, "_done"}, int'(bus.o_done), want_done);
    check({tag, "_fail"}, int'(bus.o_fail), 1 - want_done);
    check({tag, "_busy_in_pulse"}, int'(bus.o_busy), 1);
    tick_clk(1);
    check({tag, "_busy_after"}, int'(bus.o_busy), 0);
    check({tag, "_pulse_width"}, int'(bus.o_done | bus.o_fail), 0);
  endtask

  int p0, s0, a0;

  initial begin
    bus.i_start = 1'b0;
    rst = 1'b1;
    tick_clk(3);
    check("reset_outputs", int'({bus.o_busy, bus.o_scl_oe, bus.o_sda_oe, bus.o_done, bus.o_fail}), 0);
    rst = 1'b0;
    tick_clk(4);

    // A: target lets go of SDA after 3 pulses.
    tgt_sda_en = 1'b1; rel_after = 3; base_high = n_high;
    p0 = n_pulse; s0 = n_stop;
    pulse_start();
    check("A_first_drive", int'({bus.o_busy, bus.o_scl_oe, bus.o_sda_oe}), 3'b110);
    wait_end("A", 1);
    check("A_pulses", n_pulse - p0, 3);
    check("A_stop", n_stop - s0, 1);
    tick_clk(4);

    // B: SDA never released; a second request mid-run is dropped.
    rel_after = 100; base_high = n_high;
    p0 = n_pulse; s0 = n_stop;
    pulse_start();
    tick_clk(20);
    pulse_start();
    wait_end("B", 0);
    check("B_pulses", n_pulse - p0, 9);
    check("B_no_stop", n_stop - s0, 0);
    tick_clk(30);
    check("B_no_requeue", int'(bus.o_busy), 0);
    check("B_no_extra_pulse", n_pulse - p0, 9);

    // C: SCL held low by someone else at request time.
    scl_force = 1'b1; a0 = n_any_oe;
    pulse_start();
    check("C_fail_next_cycle", int'({bus.o_busy, bus.o_fail, bus.o_done}), 3'b110);
    tick_clk(1);
    check("C_busy_after", int'(bus.o_busy), 0);
    check("C_never_drove", n_any_oe - a0, 0);
    $display("C: immediate fail, drive cycles=%0d", n_any_oe - a0);
    scl_force = 1'b0;
    tick_clk(4);

    // D: 5-tick stretch on pulse 2 stays under the limit of 8.
    rel_after = 3; str_pulse = 2; str_len = 5; base_high = n_high;
    p0 = n_pulse; s0 = n_stop;
    pulse_start();
    wait_end("D", 1);
    check("D_pulses", n_pulse - p0, 3);
    check("D_stop", n_stop - s0, 1);
    tick_clk(4);

    // E: 10-tick stretch on pulse 2 exceeds the limit.
    str_len = 10; base_high = n_high;
    p0 = n_pulse; s0 = n_stop;
    pulse_start();
    wait_end("E", 0);
    check("E_pulses", n_pulse - p0, 2);
    check("E_no_stop", n_stop - s0, 0);
    str_pulse = 0;
    tick_clk(50);

    // F: SDA already high, straight to STOP.
    tgt_sda_en = 1'b0; base_high = n_high;
    p0 = n_pulse; s0 = n_stop;
    pulse_start();
    check("F_stop_setup", int'({bus.o_busy, bus.o_scl_oe, bus.o_sda_oe}), 3'b111);
    wait_end("F", 1);
    check("F_pulses", n_pulse - p0, 0);
    check("F_stop", n_stop - s0, 1);
    tick_clk(4);

    // H: release seen on the last allowed pulse still ends in STOP.
    tgt_sda_en = 1'b1; rel_after = 9; base_high = n_high;
    p0 = n_pulse; s0 = n_stop;
    pulse_start();
    wait_end("H", 1);
    check("H_pulses", n_pulse - p0, 9);
    check("H_stop", n_stop - s0, 1);
    tick_clk(4);

    // G: reset in the middle of the first low phase, then a clean restart.
    rel_after = 100; base_high = n_high;
    pulse_start();
    tick_clk(3);
    check("G_in_scl_low", int'({bus.o_busy, bus.o_scl_oe}), 2'b11);
    rst = 1'b1;
    tick_clk(1);
    check("G_reset_release", int'({bus.o_busy, bus.o_scl_oe, bus.o_sda_oe, bus.o_done, bus.o_fail}), 0);
    $display("G: reset mid-sequence, outputs=%0b", {bus.o_busy, bus.o_scl_oe, bus.o_sda_oe, bus.o_done, bus.o_fail});
    rst = 1'b0;
    tick_clk(3);
    rel_after = 2; base_high = n_high;
    p0 = n_pulse; s0 = n_stop;
    pulse_start();
    wait_end("G", 1);
    check("G_pulses", n_pulse - p0, 2);
    check("G_stop", n_stop - s0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_passthru_bus_recover.md
# i2c_passthru_bus_recover

Drives the I2C bus-clear sequence, complementing the passive idle/stuck detector. On request, typically when the detector flags a stuck bus, it releases SDA, clocks SCL up to RECOVER_PULSES times until the target releases SDA, then generates a STOP. SMBus t_low spacing comes from the shared i_f_ref tick. It sits beside the passthru core and drives the open-drain enables for one bus side.

## Interface
- F_REF_T_LOW, 38, i_f_ref ticks per bus phase (t_low / t_high / t_su_sto / t_buf)
- WIDTH_F_REF_T_LOW, 6, width of the phase timer, ceil(log2(F_REF_T_LOW+1))
- RECOVER_PULSES, 9, maximum SCL pulses before failure (1..15)
- STRETCH_MAX, 255, i_f_ref ticks SCL may be held low externally while released
- WIDTH_STRETCH, 8, width of the stretch counter
- i_clk  input  1  system clock; all logic on its rising edge
- i_rst  input  1  synchronous reset, active-high
- i_f_ref  input  1  reference tick; a rising edge (sampled ~prev & cur) is one tick
- i_start  input  1  one-cycle recovery request; ignored unless idle
- i_sda  input  1  sampled bus SDA
- i_scl  input  1  sampled bus SCL
- o_scl_oe  output  1  1 = pull SCL low
- o_sda_oe  output  1  1 = pull SDA low
- o_busy  output  1  high in every state except ST_IDLE
- o_done  output  1  one-cycle pulse, bus recovered and STOP issued
- o_fail  output  1  one-cycle pulse, recovery aborted

## Operation
- Phase timer: loaded with F_REF_T_LOW on every state entry and decremented on each i_f_ref tick. The phase ends in the cycle where the timer equals 0 and the phase condition holds.
- States and transitions:
  - ST_IDLE: no drive. On i_start:
    - i_scl=0 goes to ST_FAIL; SCL held by another agent is unrecoverable.
    - i_sda=1 goes to ST_STOP_SETUP.
    - Otherwise goes to ST_SCL_LOW, with pulse counter set to 0.
  - ST_SCL_LOW: o_scl_oe=1, SDA released. Timer end goes to ST_SCL_HIGH.
  - ST_SCL_HIGH: SCL released.
    - While i_scl=0 the timer is reloaded and the stretch counter counts ticks. Stretch counter == STRETCH_MAX goes to ST_FAIL.
    - At timer end, the pulse counter increments.
    - If i_sda=1, go to ST_STOP_SETUP.
    - Else if the incremented count == RECOVER_PULSES, go to ST_FAIL.
    - Else go to ST_SCL_LOW.
  - ST_STOP_SETUP: o_scl_oe=1, o_sda_oe=1. Timer end goes to ST_STOP_SCL_HI.
  - ST_STOP_SCL_HI: SCL released, o_sda_oe=1. Stretch handling is the same as in ST_SCL_HIGH. Timer end goes to ST_STOP_SDA_HI.
  - ST_STOP_SDA_HI: both released (this is the STOP edge). At timer end, i_sda & i_scl both 1 goes to ST_DONE, otherwise ST_FAIL.
  - ST_DONE: o_done=1, then ST_IDLE.
  - ST_FAIL: o_fail=1, then ST_IDLE.
- The stretch counter clears on every state entry and saturates at STRETCH_MAX.
- Outputs are a combinational decode of the state register only; they are never driven from raw inputs.
- An undefined state encoding goes to ST_IDLE.

## Timing
- Reset: the state, timers and counters clear in the cycle after the i_rst edge. All outputs are 0 from then on, and i_rst asserted mid-sequence releases both lines that same cycle.
- i_start to first drive: o_busy and o_scl_oe rise in the cycle after i_start is sampled.
- Phase length:
  - Minimum: F_REF_T_LOW ticks, plus up to one tick period of alignment, plus 1 clk.
  - Maximum: unbounded by the timer while stretched, bounded by STRETCH_MAX.
- o_done and o_fail are exactly 1 cycle wide, mutually exclusive, and o_busy is high in that cycle.
- o_busy falls the cycle after the pulse.
- i_start while o_busy=1 is dropped and never queued.
- An SDA release detected on the final allowed pulse goes to ST_STOP_SETUP, not to failure; the SDA check takes priority over the count check.
- The counter stays within 4 bits; RECOVER_PULSES>15 is unsupported.

## Test plan
Common bench settings: F_REF_T_LOW=4, i_f_ref high for 1 clk of every 4, target modelled as open-drain.

- Target releases SDA after 3 pulses → exactly 3 o_scl_oe low periods, then STOP (SDA rises while SCL high), o_done pulse, 0 o_fail.
- SDA never released → 9 SCL pulses, no STOP, o_fail one cycle, o_busy drops the next cycle.
- i_scl=0 at i_start → o_fail the cycle after i_start, o_scl_oe/o_sda_oe never asserted.
- Target stretches SCL for 10 ticks in pulse 2 (STRETCH_MAX=255) → high phase extended, recovery completes with o_done. Repeat with STRETCH_MAX=8 → o_fail.
- i_sda=1 at i_start → no SCL pulses, STOP_SETUP→STOP_SCL_HI→STOP_SDA_HI, o_done.
- i_rst asserted during ST_SCL_LOW → next cycle all outputs 0; a subsequent i_start restarts cleanly at pulse count 0.
